// File: rtl/ctrl_fifo_pkg.sv
// Shared constants, the serializer byte-index type and a clog2 helper
// for the inbound control-path FIFO.
package ctrl_fifo_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);

    // Ceiling log2, used to derive pointer widths from DEPTH.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ctrl_if_fifo_if.sv
// Host-word / CPU-byte bus of the inbound control FIFO.
// slave: the FIFO itself; master: host writer plus CPU reader.
interface ctrl_if_fifo_if
    import ctrl_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = clog2(DEPTH);

    logic              flush;
    logic              wr;
    logic [WORD_W-1:0] wdata;
    logic              wrfull;
    logic [ADDR_W:0]   wrusedw;
    logic              rd;
    logic [BYTE_W-1:0] q;
    logic              rdempty;
    logic [7:0]        ovf_cnt;
    logic              udf;

    modport master (
        output flush, wr, wdata, rd,
        input  wrfull, wrusedw, q, rdempty, ovf_cnt, udf
    );

    modport slave (
        input  flush, wr, wdata, rd,
        output wrfull, wrusedw, q, rdempty, ovf_cnt, udf
    );

endinterface

// File: rtl/ctrl_fifo_mem.sv
// Simple dual-port word store: synchronous write, asynchronous read.
module ctrl_fifo_mem
    import ctrl_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Write port: store the word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ctrl_if_fifo.sv
// Inbound control-path FIFO: 32-bit host words in, show-ahead
// little-endian byte stream out to the control CPU.
// Optional statistics (ovf_cnt, udf) enabled by CTRL_IF_FIFO_STATS_EN.
module ctrl_if_fifo
    import ctrl_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic           clk,
    input logic           reset,
    ctrl_if_fifo_if.slave bus
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WORD_W-1:0] ser_data_q, ser_data_d;
    byte_idx_t         ser_idx_q, ser_idx_d;
    logic              ser_vld_q, ser_vld_d;

    logic              wrfull;
    logic              wr_accept;
    logic              pop;
    logic              load;
    logic [WORD_W-1:0] mem_rdata;
    logic [BYTE_W-1:0] sel_byte;

    assign wrfull = (count_q == CNT_DEPTH);

    ctrl_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr_q),
        .wdata (bus.wdata),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    // Next state for pointers, count and serializer; flush overrides all.
    // A pop of the last byte and a reload share one edge so a held rd
    // streams across word boundaries without a bubble.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ser_data_d = ser_data_q;
        ser_idx_d  = ser_idx_q;
        ser_vld_d  = ser_vld_q;
        wr_accept  = bus.wr && !wrfull && !bus.flush;
        pop        = bus.rd && ser_vld_q;
        load       = !bus.flush && (count_q != '0) &&
                     (!ser_vld_q || (pop && (ser_idx_q == LAST_BYTE)));
        if (bus.flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            count_d   = '0;
            ser_idx_d = '0;
            ser_vld_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (load) begin
                rptr_d     = rptr_q + PTR_ONE;
                ser_data_d = mem_rdata;
                ser_idx_d  = '0;
                ser_vld_d  = 1'b1;
            end else if (pop) begin
                if (ser_idx_q == LAST_BYTE) begin
                    ser_vld_d = 1'b0;
                end else begin
                    ser_idx_d = ser_idx_q + byte_idx_t'(1);
                end
            end
            if (wr_accept && !load) begin
                count_d = count_q + CNT_ONE;
            end else if (!wr_accept && load) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ser_data_q <= '0;
            ser_idx_q  <= '0;
            ser_vld_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ser_data_q <= ser_data_d;
            ser_idx_q  <= ser_idx_d;
            ser_vld_q  <= ser_vld_d;
        end
    end

    // Little-endian byte select from the holding register.
    always_comb begin
        sel_byte = '0;
        case (ser_idx_q)
            2'd0:    sel_byte = ser_data_q[7:0];
            2'd1:    sel_byte = ser_data_q[15:8];
            2'd2:    sel_byte = ser_data_q[23:16];
            default: sel_byte = ser_data_q[31:24];
        endcase
    end

    assign bus.q       = ser_vld_q ? sel_byte : '0;
    assign bus.rdempty = !ser_vld_q;
    assign bus.wrfull  = wrfull;
    assign bus.wrusedw = count_q;

`ifdef CTRL_IF_FIFO_STATS_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;
    logic       udf_q, udf_d;

    // Saturating drop counter and sticky underflow flag; flush clears both.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_d     = udf_q;
        if (bus.flush) begin
            ovf_cnt_d = '0;
            udf_d     = 1'b0;
        end else begin
            if (bus.wr && wrfull && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
            if (bus.rd && !ser_vld_q) begin
                udf_d = 1'b1;
            end
        end
    end

    // Statistics registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
            udf_q     <= 1'b0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_q     <= udf_d;
        end
    end

    assign bus.ovf_cnt = ovf_cnt_q;
    assign bus.udf     = udf_q;
`else
    assign bus.ovf_cnt = '0;
    assign bus.udf     = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_if_fifo.sv
// Directed bench for ctrl_if_fifo (DEPTH=16); statistics expectations
// follow CTRL_IF_FIFO_STATS_EN.
module tb_ctrl_if_fifo;

`ifdef CTRL_IF_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ctrl_if_fifo_if #(.DEPTH(16)) bus ();

    ctrl_if_fifo #(.DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL reset_rdempty got=%b exp=1", bus.rdempty); end
        checks++; if (bus.wrfull !== 1'b0) begin failures++; $display("FAIL reset_wrfull got=%b exp=0", bus.wrfull); end
        checks++; if (bus.wrusedw !== 5'd0) begin failures++; $display("FAIL reset_wrusedw got=%0d exp=0", bus.wrusedw); end
        checks++; if (bus.q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", bus.q); end
        checks++; if (bus.ovf_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", bus.ovf_cnt); end
        checks++; if (bus.udf !== 1'b0) begin failures++; $display("FAIL reset_udf got=%b exp=0", bus.udf); end
        reset = 1'b0;
        tick();
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL post_reset_rdempty got=%b exp=1", bus.rdempty); end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        bus.wr = 1'b1; bus.wdata = 32'h4433_2211; bus.rd = 1'b1;
        tick();
        bus.wr = 1'b0;
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL single_latency_rdempty got=%b exp=1", bus.rdempty); end
        checks++; if (bus.wrusedw !== 5'd1) begin failures++; $display("FAIL single_wrusedw got=%0d exp=1", bus.wrusedw); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rdempty !== 1'b0 || bus.q !== exp_b[i]) begin failures++; $display("FAIL single_byte%0d got=%h empty=%b exp=%h", i, bus.q, bus.rdempty, exp_b[i]); end
            tick();
        end
        bus.rd = 1'b0;
        checks++; if (bus.rdempty !== 1'b1 || bus.q !== 8'h00) begin failures++; $display("FAIL single_drained empty=%b q=%h exp empty=1 q=00", bus.rdempty, bus.q); end
    endtask

    task automatic test_back_to_back();
        bus.wr = 1'b1; bus.wdata = 32'h0302_0100; bus.rd = 1'b1;
        tick();
        bus.wdata = 32'h0706_0504;
        tick();
        checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'h00) begin failures++; $display("FAIL b2b_byte0 got=%h empty=%b exp=00", bus.q, bus.rdempty); end
        bus.wdata = 32'h0B0A_0908;
        tick();
        bus.wr = 1'b0;
        checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'h01) begin failures++; $display("FAIL b2b_byte1 got=%h empty=%b exp=01", bus.q, bus.rdempty); end
        for (int i = 2; i < 12; i++) begin
            tick();
            checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'(i)) begin failures++; $display("FAIL b2b_byte%0d got=%h empty=%b exp=%h", i, bus.q, bus.rdempty, 8'(i)); end
        end
        tick();
        bus.rd = 1'b0;
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL b2b_drained got=%b exp=1", bus.rdempty); end
    endtask

    task automatic test_full();
        logic [7:0] exp_ovf;
        exp_ovf = STATS ? 8'd1 : 8'd0;
        bus.rd = 1'b0;
        for (int k = 0; k < 18; k++) begin
            bus.wr = 1'b1;
            bus.wdata = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            tick();
            if (k == 16) begin
                checks++; if (bus.wrfull !== 1'b1 || bus.wrusedw !== 5'd16) begin failures++; $display("FAIL full_reached full=%b used=%0d exp full=1 used=16", bus.wrfull, bus.wrusedw); end
            end
        end
        bus.wr = 1'b0;
        checks++; if (bus.wrfull !== 1'b1) begin failures++; $display("FAIL full_wrfull got=%b exp=1", bus.wrfull); end
        checks++; if (bus.wrusedw !== 5'd16) begin failures++; $display("FAIL full_wrusedw got=%0d exp=16", bus.wrusedw); end
        checks++; if (bus.ovf_cnt !== exp_ovf) begin failures++; $display("FAIL full_ovf got=%0d exp=%0d", bus.ovf_cnt, exp_ovf); end
        bus.rd = 1'b1;
        for (int j = 0; j < 68; j++) begin
            checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'(j)) begin failures++; $display("FAIL full_byte%0d got=%h empty=%b exp=%h", j, bus.q, bus.rdempty, 8'(j)); end
            tick();
        end
        bus.rd = 1'b0;
        checks++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 5'd0) begin failures++; $display("FAIL full_drained empty=%b used=%0d exp empty=1 used=0", bus.rdempty, bus.wrusedw); end
    endtask

    task automatic test_read_empty();
        logic exp_udf;
        exp_udf = STATS;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.udf !== 1'b0 || bus.ovf_cnt !== 8'd0) begin failures++; $display("FAIL empty_preflush udf=%b ovf=%0d exp 0/0", bus.udf, bus.ovf_cnt); end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        checks++; if (bus.udf !== exp_udf) begin failures++; $display("FAIL empty_udf got=%b exp=%b", bus.udf, exp_udf); end
        checks++; if (bus.q !== 8'h00 || bus.rdempty !== 1'b1 || bus.wrusedw !== 5'd0) begin failures++; $display("FAIL empty_state q=%h empty=%b used=%0d exp 00/1/0", bus.q, bus.rdempty, bus.wrusedw); end
        bus.wr = 1'b1; bus.wdata = 32'h0D0C_0B0A;
        tick();
        bus.wr = 1'b0;
        tick();
        bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'(10 + i)) begin failures++; $display("FAIL empty_after_byte%0d got=%h exp=%h", i, bus.q, 8'(10 + i)); end
            tick();
        end
        bus.rd = 1'b0;
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL empty_after_drained got=%b exp=1", bus.rdempty); end
    endtask

    task automatic test_flush();
        bus.wr = 1'b1; bus.wdata = 32'h1312_1110;
        tick();
        bus.wdata = 32'h1716_1514;
        tick();
        bus.wr = 1'b0; bus.rd = 1'b1;
        tick();
        tick();
        checks++; if (bus.q !== 8'h12 || bus.wrusedw !== 5'd1) begin failures++; $display("FAIL flush_pre q=%h used=%0d exp 12/1", bus.q, bus.wrusedw); end
        bus.flush = 1'b1; bus.wr = 1'b1; bus.wdata = 32'h5555_5555;
        tick();
        bus.flush = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        checks++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 5'd0 || bus.q !== 8'h00) begin failures++; $display("FAIL flush_state empty=%b used=%0d q=%h exp 1/0/00", bus.rdempty, bus.wrusedw, bus.q); end
        checks++; if (bus.ovf_cnt !== 8'd0 || bus.udf !== 1'b0) begin failures++; $display("FAIL flush_stats ovf=%0d udf=%b exp 0/0", bus.ovf_cnt, bus.udf); end
        repeat (2) tick();
        checks++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 5'd0) begin failures++; $display("FAIL flush_write_dropped empty=%b used=%0d exp 1/0", bus.rdempty, bus.wrusedw); end
        bus.wr = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.wr = 1'b0;
        tick();
        checks++; if (bus.rdempty !== 1'b0 || bus.q !== 8'hEF) begin failures++; $display("FAIL flush_next_word q=%h empty=%b exp EF/0", bus.q, bus.rdempty); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.wr = 1'b1; bus.wdata = 32'h8765_4321;
        tick();
        bus.wdata = 32'h0FED_CBA9;
        tick();
        bus.wr = 1'b0;
        checks++; if (bus.q !== 8'h21 || bus.wrusedw !== 5'd1) begin failures++; $display("FAIL areset_pre q=%h used=%0d exp 21/1", bus.q, bus.wrusedw); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.rdempty !== 1'b1 || bus.q !== 8'h00 || bus.wrusedw !== 5'd0 || bus.wrfull !== 1'b0) begin failures++; $display("FAIL areset_immediate empty=%b q=%h used=%0d full=%b exp 1/00/0/0", bus.rdempty, bus.q, bus.wrusedw, bus.wrfull); end
        #1;
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (bus.rdempty !== 1'b1 || bus.wrusedw !== 5'd0) begin failures++; $display("FAIL areset_after empty=%b used=%0d exp 1/0", bus.rdempty, bus.wrusedw); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.flush = 1'b0;
        bus.wr    = 1'b0;
        bus.wdata = '0;
        bus.rd    = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full();
        test_read_empty();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_if_fifo.md
Name: ctrl_if_fifo

Overview:
- Inbound control-path FIFO between the host (PCIe) control endpoint and the embedded control CPU's external-FIFO input interface.
- Accepts 32-bit words from the host side and presents them to the CPU as a byte stream.
- The byte-read port is show-ahead: read data is valid whenever the empty flag is low.
- Provides the data, read-strobe and empty signals that the CPU's byte-read FIFO port consumes, plus a flush driven by the CPU's FIFO-reset output.

Parameters:
- DEPTH, 16, word storage depth. Power of two, ≥2.
- ADDR_W, log2(DEPTH), pointer width. Derived; do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear from the CPU FIFO-reset output; level-sensitive
- wr  in  1  host word write strobe
- wdata  in  32  host word
- wrfull  out  1  word storage full
- wrusedw  out  ADDR_W+1  words held in storage (excludes serializer)
- rd  in  1  byte pop strobe from the CPU
- q  out  8  current byte (show-ahead)
- rdempty  out  1  no byte available
- ovf_cnt  out  8  dropped-write counter (optional feature)
- udf  out  1  sticky read-while-empty flag (optional feature)

Behaviour:
- Reset (async, asserted): wrfull=0, wrusedw=0, rdempty=1, q=0, pointers=0, serializer empty, ovf_cnt=0, udf=0.
- Storage: DEPTH×32 register array.
  - Write pointer advances on an accepted write (wr && !wrfull && !flush).
  - Read pointer advances on a serializer load.
  - wrusedw = count; wrfull = (count==DEPTH).
  - Total capacity is DEPTH+1 words (storage plus serializer).
- Serializer: 32-bit holding register, 2-bit byte index, valid bit.
  - Byte order is little-endian: byte0 = wdata[7:0] first, byte3 = wdata[31:24] last.
  - q = selected byte when valid, else 0. rdempty = !valid.
- Pop: rd && !rdempty advances the index.
  - On a pop of byte3, the serializer reloads in the same edge if storage is non-empty, else valid clears.
  - Result: no bubble across word boundaries when rd is held high.
- Idle load: serializer not valid and count>0 → load at next edge, index=0.
- Latency: word written at edge E0 into an empty FIFO → rdempty falls after E1, with q=wdata[7:0] visible.
- Read of empty (rd && rdempty): ignored; no state change except udf.
- Write to full (wr && wrfull): word dropped; ovf_cnt increments.
- Simultaneous accepted write and serializer load: count unchanged, both pointers advance.
  - A write to a full FIFO in the same cycle as a load is still dropped: wrfull is evaluated on registered state.
- Flush (highest priority after reset): at the edge it is sampled
  - pointers=0, count=0, serializer invalid, q=0;
  - wr/rd in the same cycle are ignored;
  - ovf_cnt and udf are also cleared.
  - Held high, the FIFO stays empty.
- Reset mid-transfer: all state lost immediately (async). No partial-word recovery.
- Pointer wrap: modulo DEPTH. Count is computed separately, so there is no full/empty ambiguity.

Optional Feature:
- Macro CTRL_IF_FIFO_STATS_EN.
- Defined:
  - ovf_cnt is an 8-bit counter of dropped writes, saturating at 255.
  - udf is sticky high after any rd while rdempty.
  - Both are cleared by reset or flush.
- Undefined: ovf_cnt tied to 0, udf tied to 0, and no counter logic is synthesized.

Decomposition:
- Package ctrl_fifo_pkg holds:
  - BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4;
  - byte-index type (2 bits);
  - clog2 function, used for ADDR_W.
- Sub-module ctrl_fifo_mem: simple dual-port register array.
  - Write port: we, waddr, wdata.
  - Asynchronous read port: raddr → rdata.
  - Instantiated once. Pointers, count, serializer and stats stay in ctrl_if_fifo.

Test Plan:
1. Reset, then write 0x44332211; rd held high → rdempty falls one edge after write; q sequence 0x11,0x22,0x33,0x44; rdempty=1 after the fourth pop.
2. Write 3 words 0x03020100, 0x07060504, 0x0B0A0908; rd continuous → 12 bytes 0x00..0x0B on consecutive cycles, no bubble.
3. DEPTH=16: write 18 words with no reads → wrfull=1 with wrusedw=16 once the serializer has loaded the first word; the 18th word is dropped and ovf_cnt=1 (STATS_EN); pop all → exactly 17 words (68 bytes) in order.
4. rd pulsed while empty → q stays 0, pointers unchanged, udf=1 (STATS_EN) or 0 (without).
5. Flush asserted mid-word (after 2 pops), with wr active in the same cycle → rdempty=1, wrusedw=0, q=0, that write not stored, ovf_cnt=0 and udf=0; next write 0xDEADBEEF → q=0xEF first.
6. Async reset asserted between clock edges while data is buffered → outputs return to reset values immediately, without waiting for a clock edge.
